id_ex_stage: RTL and testbench

//  ID/EX pipeline register fed by the decoder's control bundle and register-file reads.

---
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use hazard stall, redirect slot kill and a
// saturating count of the bubbles inserted into EX.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_dst,
  input  logic [2:0]       id_aluop,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [DW-1:0]    id_pc4,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_redirect,
  output logic             stall,
  output logic             redirect_ok,
  output logic             ex_regwrite,
  output logic             ex_memtoreg,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_dst,
  output logic [2:0]       ex_aluop,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [DW-1:0]    ex_pc4,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             ex_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic w_haz;
  logic w_bubble;
  logic w_cnt_sat;

  // Both source fields are compared regardless of opcode (conservative).
  assign w_haz       = ex_valid & ex_memread & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign w_bubble    = w_haz | id_redirect;
  assign w_cnt_sat   = (bubble_cnt == {CNT_W{1'b1}});
  assign stall       = w_haz;
  assign redirect_ok = id_redirect & ~w_haz;

  // Pipeline register; a bubble only needs the control bits and valid cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_dst      <= 1'b0;
      ex_aluop    <= 3'd0;
      ex_valid    <= 1'b0;
      ex_rs_data  <= {DW{1'b0}};
      ex_rt_data  <= {DW{1'b0}};
      ex_imm      <= {DW{1'b0}};
      ex_pc4      <= {DW{1'b0}};
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
    end else begin
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      if (w_bubble) begin
        ex_regwrite <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_dst      <= 1'b0;
        ex_aluop    <= 3'd0;
        ex_valid    <= 1'b0;
      end else begin
        ex_regwrite <= id_regwrite;
        ex_memtoreg <= id_memtoreg;
        ex_memread  <= id_memread;
        ex_memwrite <= id_memwrite;
        ex_alusrc   <= id_alusrc;
        ex_dst      <= id_dst;
        ex_aluop    <= id_aluop;
        ex_valid    <= 1'b1;
      end
    end
  end

  // Bubble counter holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (w_bubble && !w_cnt_sat) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a 16-bit-counter instance and a 2-bit one share stimulus.
module tb_id_ex_stage;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [8:0] id_ctl;
  logic id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_dst;
  logic [2:0] id_aluop;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_redirect;

  logic stall, redirect_ok, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_dst, ex_valid;
  logic [2:0] ex_aluop;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [15:0] bubble_cnt;

  logic s_stall, s_redirect_ok, s_ex_regwrite, s_ex_memtoreg, s_ex_memread, s_ex_memwrite, s_ex_alusrc, s_ex_dst, s_ex_valid;
  logic [2:0] s_ex_aluop;
  logic [DW-1:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm, s_ex_pc4;
  logic [4:0] s_ex_rs, s_ex_rt, s_ex_rd;
  logic [1:0] s_bubble_cnt;

  assign {id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_dst, id_aluop} = id_ctl;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_dst(id_dst), .id_aluop(id_aluop),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_redirect(id_redirect),
    .stall(stall), .redirect_ok(redirect_ok),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_dst(ex_dst), .ex_aluop(ex_aluop),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DW(DW), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_dst(id_dst), .id_aluop(id_aluop),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_redirect(id_redirect),
    .stall(s_stall), .redirect_ok(s_redirect_ok),
    .ex_regwrite(s_ex_regwrite), .ex_memtoreg(s_ex_memtoreg), .ex_memread(s_ex_memread),
    .ex_memwrite(s_ex_memwrite), .ex_alusrc(s_ex_alusrc), .ex_dst(s_ex_dst), .ex_aluop(s_ex_aluop),
    .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_valid(s_ex_valid), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct packed {
    logic [8:0]    ctl;
    logic          valid;
    logic [DW-1:0] rs_d, rt_d, imm, pc4;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   cnt;
    logic [1:0]    cnt2;
  } ex_t;

  localparam logic [8:0] CTL_LW  = 9'b1_1_1_0_1_0_000;
  localparam logic [8:0] CTL_ADD = 9'b1_0_0_0_0_1_010;
  localparam logic [8:0] CTL_BEQ = 9'b0_0_0_0_0_0_001;

  ex_t m;
  ex_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_haz(input ex_t s);
    return s.valid & s.ctl[6] & (s.rt != 5'd0) & ((s.rt == id_rs) | (s.rt == id_rt));
  endfunction

  function automatic ex_t calc_next(input ex_t s);
    ex_t n;
    logic bub;
    bub    = model_haz(s) | id_redirect;
    n.ctl  = bub ? 9'd0 : id_ctl;
    n.valid = ~bub;
    n.rs_d = id_rs_data; n.rt_d = id_rt_data; n.imm = id_imm; n.pc4 = id_pc4;
    n.rs   = id_rs; n.rt = id_rt; n.rd = id_rd;
    n.cnt  = (bub && s.cnt != 16'hFFFF) ? s.cnt + 16'd1 : s.cnt;
    n.cnt2 = (bub && s.cnt2 != 2'd3) ? s.cnt2 + 2'd1 : s.cnt2;
    return n;
  endfunction

  task automatic cmp_ex(input string tag, input ex_t e);
    check({tag, ".valid"}, ex_valid, e.valid);
    check({tag, ".ctl"}, {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_dst, ex_aluop}, e.ctl);
    check({tag, ".cnt"}, bubble_cnt, e.cnt);
    check({tag, ".s_valid"}, s_ex_valid, e.valid);
    check({tag, ".s_ctl"}, {s_ex_regwrite, s_ex_memtoreg, s_ex_memread, s_ex_memwrite, s_ex_alusrc, s_ex_dst, s_ex_aluop}, e.ctl);
    check({tag, ".s_cnt"}, s_bubble_cnt, e.cnt2);
    if (e.valid) begin
      check({tag, ".data"}, {ex_rs_data, ex_rt_data, ex_imm, ex_pc4}, {e.rs_d, e.rt_d, e.imm, e.pc4});
      check({tag, ".idx"}, {ex_rs, ex_rt, ex_rd}, {e.rs, e.rt, e.rd});
      check({tag, ".s_data"}, {s_ex_rs_data, s_ex_rt_data, s_ex_imm, s_ex_pc4}, {e.rs_d, e.rt_d, e.imm, e.pc4});
      check({tag, ".s_idx"}, {s_ex_rs, s_ex_rt, s_ex_rd}, {e.rs, e.rt, e.rd});
    end
  endtask

  task automatic drive(input logic [8:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic redir);
    id_ctl = ctl; id_rs = rs; id_rt = rt; id_rd = rd; id_redirect = redir;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic step(input string tag);
    ex_t n;
    logic haz;
    #2;
    haz = model_haz(m);
    check({tag, ".stall"}, stall, haz);
    check({tag, ".redirect_ok"}, redirect_ok, id_redirect & ~haz);
    check({tag, ".s_stall"}, s_stall, haz);
    check({tag, ".s_redirect_ok"}, s_redirect_ok, id_redirect & ~haz);
    sb.push_back(calc_next(m));
    @(posedge clk);
    #1;
    n = sb.pop_front();
    cmp_ex(tag, n);
    m = n;
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0;
    drive(9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
    #3;
    cmp_ex("rst", m);
    check("rst.stall", stall, 1'b0);
    @(posedge clk);
    #1;
    cmp_ex("rst_edge", m);
    rst_n = 1'b1;

    drive(CTL_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    step("add");
    check("add.aluop", ex_aluop, 3'd2);

    drive(CTL_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    step("lu.lw");
    drive(CTL_ADD, 5'd5, 5'd6, 5'd7, 1'b0);
    #1 check("lu.stall_hi", stall, 1'b1);
    step("lu.stall");
    step("lu.issue");
    check("lu.cnt", bubble_cnt, 16'd1);
    check("lu.issued", ex_valid, 1'b1);

    drive(CTL_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    step("r0.lw");
    drive(CTL_ADD, 5'd0, 5'd0, 5'd7, 1'b0);
    #1 check("r0.no_stall", stall, 1'b0);
    step("r0.add");

    drive(CTL_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
    #1 check("rd.ok", redirect_ok, 1'b1);
    step("rd.kill");
    check("rd.cnt", bubble_cnt, 16'd2);

    drive(CTL_LW, 5'd1, 5'd4, 5'd0, 1'b0);
    step("sb.lw");
    drive(CTL_BEQ, 5'd4, 5'd2, 5'd0, 1'b1);
    #1 check("sb.ok_lo", redirect_ok, 1'b0);
    step("sb.stall");
    #1 check("sb.ok_hi", redirect_ok, 1'b1);
    step("sb.kill");
    check("sb.cnt", bubble_cnt, 16'd4);

    drive(CTL_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
    step("sat.1");
    step("sat.2");
    check("sat.cnt2", s_bubble_cnt, 2'd3);
    check("sat.cnt16", bubble_cnt, 16'd6);

    drive(CTL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    step("ar.lw");
    drive(CTL_ADD, 5'd9, 5'd2, 5'd3, 1'b0);
    #2 check("ar.stall", stall, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ar.valid", ex_valid, 1'b0);
    check("ar.memread", ex_memread, 1'b0);
    check("ar.stall_clr", stall, 1'b0);
    check("ar.cnt", bubble_cnt, 16'd0);
    check("ar.s_cnt", s_bubble_cnt, 2'd0);
    #1 rst_n = 1'b1;
    m = '0;
    step("ar.first");
    check("ar.first_valid", ex_valid, 1'b1);

    for (int i = 0; i < 60; i++) begin
      drive(9'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), ($urandom_range(0, 4) == 0));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
